// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-stage instruction fetch with a valid/ready output
//               register, redirect, an address-limit fault and an optional
//               alignment check. The check is enabled by FETCH_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_out_pc;
  logic [31:0] w_out_pc_nxt;
  logic        r_fault;
  logic        w_fault_nxt;
  logic        r_misaligned;
  logic        w_misaligned_nxt;
  logic [31:0] w_redirect_tgt;
  logic        w_pc_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_redirect_tgt  = redirect_pc;
  assign w_pc_misaligned = (r_pc[1:0] != 2'b00);
`else
  // Low bits are dropped at load, so the PC can never become misaligned.
  logic w_unused_redirect_lsb;
  assign w_unused_redirect_lsb = ^redirect_pc[1:0];
  assign w_redirect_tgt        = {redirect_pc[31:2], 2'b00};
  assign w_pc_misaligned       = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_valid_nxt      = r_valid;
    w_instr_nxt      = r_instr;
    w_out_pc_nxt     = r_out_pc;
    w_fault_nxt      = r_fault;
    w_misaligned_nxt = r_misaligned;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        w_valid_nxt = 1'b0;
        if (redirect) w_pc_nxt = w_redirect_tgt;
      end
      S_FETCH: begin
        if (redirect) begin
          w_pc_nxt    = w_redirect_tgt;
          w_valid_nxt = 1'b0;
        end else if (!r_valid || out_ready) begin
          // A would-be capture from an illegal PC traps instead of fetching.
          if ((r_pc >= ADDR_LIMIT) || w_pc_misaligned) begin
            w_state_nxt      = S_FAULT;
            w_valid_nxt      = 1'b0;
            w_fault_nxt      = 1'b1;
            w_misaligned_nxt = w_pc_misaligned;
          end else begin
            w_instr_nxt  = imem_rd;
            w_out_pc_nxt = r_pc;
            w_valid_nxt  = 1'b1;
            w_pc_nxt     = r_pc + 32'd4;
          end
        end
      end
      S_FAULT: begin
        w_valid_nxt = 1'b0;
        w_fault_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_valid      <= 1'b0;
      r_instr      <= 32'h0;
      r_out_pc     <= 32'h0;
      r_fault      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_valid      <= w_valid_nxt;
      r_instr      <= w_instr_nxt;
      r_out_pc     <= w_out_pc_nxt;
      r_fault      <= w_fault_nxt;
      r_misaligned <= w_misaligned_nxt;
    end
  end

  assign imem_addr    = r_pc;
  assign out_valid    = r_valid;
  assign out_instr    = r_instr;
  assign out_pc       = r_out_pc;
  assign out_pc_plus4 = r_out_pc + 32'd4;
  assign fault        = r_fault;
  assign misaligned   = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic        misaligned;

  int n_chk;
  int n_fail;

  logic [31:0] mem [0:1023];

  fetch_unit #(.RESET_PC(32'h0), .ADDR_LIMIT(32'h1000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .fault(fault), .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rd = (imem_addr < 32'h1000) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

  function automatic logic [31:0] word_at(input int idx);
    case (idx)
      0: return 32'h2008_0005;
      1: return 32'h2009_0003;
      2: return 32'h0109_5020;
      3: return 32'hAC0A_0000;
      default: return 32'hA500_0000 | 32'(idx);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across an edge, then releases it 1 time unit after a posedge.
  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_chk++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", out_instr); end
    n_chk++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_chk++; if (fault !== 1'b0 || misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b%b want 00", fault, misaligned); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_i [0:3];
    exp_i[0] = 32'h2008_0005; exp_i[1] = 32'h2009_0003;
    exp_i[2] = 32'h0109_5020; exp_i[3] = 32'hAC0A_0000;
    do_reset();
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i*4) || out_instr !== exp_i[i] || out_pc_plus4 !== 32'(i*4+4)) begin
        n_fail++;
        $display("FAIL seq%0d: got v=%b pc=%h instr=%h pc4=%h want v=1 pc=%h instr=%h pc4=%h",
                 i, out_valid, out_pc, out_instr, out_pc_plus4, 32'(i*4), exp_i[i], 32'(i*4+4));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    tick();
    n_chk++; if (out_pc !== 32'h4) begin n_fail++; $display("FAIL stall_setup: got %h want 4", out_pc); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h2009_0003 || imem_addr !== 32'h8) begin
        n_fail++;
        $display("FAIL stall%0d: got v=%b pc=%h instr=%h addr=%h want v=1 pc=4 instr=20090003 addr=8",
                 i, out_valid, out_pc, out_instr, imem_addr);
      end
    end
    out_ready = 1'b1;
    tick();
    n_chk++; if (out_pc !== 32'h8 || out_instr !== 32'h0109_5020 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got v=%b pc=%h instr=%h want v=1 pc=8 instr=01095020", out_valid, out_pc, out_instr); end
  endtask

  // Continues from test_stall: out_pc=0x8 held.
  task automatic test_redirect();
    out_ready = 1'b0;
    tick();
    n_chk++; if (out_pc !== 32'h8 || imem_addr !== 32'hC) begin
      n_fail++; $display("FAIL redir_hold: got pc=%h addr=%h want pc=8 addr=c", out_pc, imem_addr); end
    redirect = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    n_chk++; if (out_valid !== 1'b0 || imem_addr !== 32'h20) begin
      n_fail++; $display("FAIL redir_flush: got v=%b addr=%h want v=0 addr=20", out_valid, imem_addr); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== 32'(32'h20 + i*4) || out_instr !== word_at(8 + i)) begin
        n_fail++;
        $display("FAIL redir_run%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, 32'(32'h20 + i*4), word_at(8 + i));
      end
    end
  endtask

  task automatic test_misaligned_redirect();
    do_reset();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h22;
    tick();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    n_chk++; if (imem_addr !== 32'h22) begin n_fail++; $display("FAIL mis_load: got %h want 22", imem_addr); end
    tick();
    n_chk++; if (fault !== 1'b1 || misaligned !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mis_fault: got f=%b m=%b v=%b want f=1 m=1 v=0", fault, misaligned, out_valid); end
`else
    n_chk++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL mis_load: got %h want 20", imem_addr); end
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || fault !== 1'b0 || misaligned !== 1'b0) begin
      n_fail++; $display("FAIL mis_deliver: got v=%b pc=%h f=%b m=%b want v=1 pc=20 f=0 m=0", out_valid, out_pc, fault, misaligned); end
`endif
  endtask

  task automatic test_addr_limit();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFF0;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== 32'(32'hFF0 + i*4) || out_instr !== word_at(32'hFF0/4 + i)) begin
        n_fail++;
        $display("FAIL lim_run%0d: got v=%b pc=%h instr=%h want v=1 pc=%h", i, out_valid, out_pc, out_instr, 32'(32'hFF0 + i*4));
      end
    end
    tick();
    n_chk++; if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h1000 || misaligned !== 1'b0) begin
      n_fail++; $display("FAIL lim_fault: got f=%b v=%b addr=%h m=%b want f=1 v=0 addr=1000 m=0", fault, out_valid, imem_addr, misaligned); end
    redirect = 1'b1;
    redirect_pc = 32'h0;
    tick();
    tick();
    redirect = 1'b0;
    n_chk++; if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h1000) begin
      n_fail++; $display("FAIL lim_sticky: got f=%b v=%b addr=%h want f=1 v=0 addr=1000", fault, out_valid, imem_addr); end
  endtask

  // Continues from test_addr_limit: unit is in FAULT.
  task automatic test_async_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_chk++; if (fault !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_fail++; $display("FAIL arst_now: got f=%b v=%b addr=%h pc=%h instr=%h want all 0", fault, out_valid, imem_addr, out_pc, out_instr); end
    tick();
    reset = 1'b0;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_idle: got %b want 0", out_valid); end
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h2008_0005 || fault !== 1'b0) begin
      n_fail++; $display("FAIL arst_resume: got v=%b pc=%h instr=%h f=%b want v=1 pc=0 instr=20080005 f=0", out_valid, out_pc, out_instr, fault); end
  endtask

  task automatic test_wrap_limit();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    n_chk++; if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_fault: got f=%b v=%b addr=%h want f=1 v=0 addr=fffffffc", fault, out_valid, imem_addr); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = word_at(i);
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misaligned_redirect();
    test_addr_limit();
    test_async_reset();
    test_wrap_limit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
